// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Lets two requesters share one combinational add/sub ALU. It accepts one
//   operation at a time through valid/ready handshakes and uses round-robin
//   arbitration when both requesters are valid. The operands are held in
//   registers that drive the ALU. The result and eq flag are captured and
//   returned on one response channel, tagged with the requester ID.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   reqN_valid / reqN_ready         requester N handshake (N = 0, 1)
//   reqN_op1, reqN_op2, reqN_ctrl   requester N operands and ALU control
//   alu_op1, alu_op2, alu_ctrl      registered operands/control to the ALU
//   alu_out, alu_eq                 ALU result and equality flag
//   resp_valid / resp_ready         response handshake
//   resp_id, resp_result, resp_eq   captured response fields
//   busy                            high while an operation is in flight
module alu_arbiter #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_op1,
  input  logic [DATA_WIDTH-1:0] req0_op2,
  input  logic [2:0]            req0_ctrl,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_op1,
  input  logic [DATA_WIDTH-1:0] req1_op2,
  input  logic [2:0]            req1_ctrl,
  output logic [DATA_WIDTH-1:0] alu_op1,
  output logic [DATA_WIDTH-1:0] alu_op2,
  output logic [2:0]            alu_ctrl,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_eq,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_id,
  output logic [DATA_WIDTH-1:0] resp_result,
  output logic                  resp_eq,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_last_grant;
  logic [DATA_WIDTH-1:0] r_alu_op1;
  logic [DATA_WIDTH-1:0] r_alu_op2;
  logic [2:0]            r_alu_ctrl;
  logic                  r_resp_id;
  logic [DATA_WIDTH-1:0] r_resp_result;
  logic                  r_resp_eq;

  logic                  w_idle;
  logic                  w_gnt_valid;
  logic                  w_gnt_id;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_sel_op1;
  logic [DATA_WIDTH-1:0] w_sel_op2;
  logic [2:0]            w_sel_ctrl;

  // Grant: if only one requester is valid, it gets the grant. On a tie the
  // grant goes to the requester that did not win last time. When neither is
  // valid, w_gnt_id = req1_valid = 0, but it is ignored.
  always_comb begin
    w_idle      = (r_state == S_IDLE);
    w_gnt_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      w_gnt_id = ~r_last_grant;
    end else begin
      w_gnt_id = req1_valid;
    end
    w_accept   = w_idle & w_gnt_valid;
    w_sel_op1  = w_gnt_id ? req1_op1  : req0_op1;
    w_sel_op2  = w_gnt_id ? req1_op2  : req0_op2;
    w_sel_ctrl = w_gnt_id ? req1_ctrl : req0_ctrl;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_gnt_valid) w_next = S_EXEC;
      S_EXEC: w_next = S_RESP;
      S_RESP: if (resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant  <= 1'b1;
      r_alu_op1     <= '0;
      r_alu_op2     <= '0;
      r_alu_ctrl    <= '0;
      r_resp_id     <= 1'b0;
      r_resp_result <= '0;
      r_resp_eq     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_alu_op1    <= w_sel_op1;
        r_alu_op2    <= w_sel_op2;
        r_alu_ctrl   <= w_sel_ctrl;
        r_resp_id    <= w_gnt_id;
        r_last_grant <= w_gnt_id;
      end
      if (r_state == S_EXEC) begin
        r_resp_result <= alu_out;
        r_resp_eq     <= alu_eq;
      end
    end
  end

  assign req0_ready  = w_accept & ~w_gnt_id;
  assign req1_ready  = w_accept &  w_gnt_id;
  assign alu_op1     = r_alu_op1;
  assign alu_op2     = r_alu_op2;
  assign alu_ctrl    = r_alu_ctrl;
  assign resp_valid  = (r_state == S_RESP);
  assign resp_id     = r_resp_id;
  assign resp_result = r_resp_result;
  assign resp_eq     = r_resp_eq;
  assign busy        = ~w_idle;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU (add/sub with zero-equality flag) between two requesters, e.g. the main execute path and an address/branch helper. Accepts one operation at a time through valid/ready handshakes, picks a requester round-robin on contention, drives the ALU from registered operands and returns the captured result and `eq` flag on a shared response channel tagged with the requester ID. Sits between the requesters and the `DATA_WIDTH`-wide ALU instance.

## Interface

- `DATA_WIDTH`, 32, operand/result width
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req0_valid`  in  1  requester 0 has an operation
- `req0_ready`  out  1  requester 0 operation accepted this cycle when high with `req0_valid`
- `req0_op1`, `req0_op2`  in  DATA_WIDTH  requester 0 operands
- `req0_ctrl`  in  3  requester 0 ALU control (0 add, 1 sub, others reserved)
- `req1_valid`, `req1_ready`, `req1_op1`, `req1_op2`, `req1_ctrl`: as above, requester 1
- `alu_op1`, `alu_op2`  out  DATA_WIDTH  registered operands to ALU
- `alu_ctrl`  out  3  registered control to ALU
- `alu_out`  in  DATA_WIDTH  ALU result (combinational from `alu_*`)
- `alu_eq`  in  1  ALU equality flag
- `resp_valid`  out  1  response available
- `resp_ready`  in  1  consumer takes response
- `resp_id`  out  1  requester that issued the operation
- `resp_result`  out  DATA_WIDTH  captured ALU result
- `resp_eq`  out  1  captured ALU eq flag
- `busy`  out  1  high in any state other than IDLE

## Operation

- FSM states: IDLE, EXEC, RESP.
- IDLE: `busy`=0. Grant chosen combinationally: only one valid -> that one; both valid -> requester not equal to `last_grant`; neither -> none. Only the granted requester's `ready` is high; the other's is 0. On grant: latch op1/op2/ctrl into `alu_*` registers, latch ID, update `last_grant`, go EXEC.
- EXEC: `alu_*` stable; at end of cycle capture `alu_out`->`resp_result`, `alu_eq`->`resp_eq`; go RESP. Both `reqX_ready`=0.
- RESP: `resp_valid`=1, `resp_id`/`resp_result`/`resp_eq` held stable. On `resp_ready`=1 go IDLE; otherwise stay (backpressure, unlimited). Both `reqX_ready`=0.
- `reqX_ready` is never high outside IDLE; no operation is accepted while a response is pending.
- `alu_ctrl` values 2-7 are passed through unchanged; the arbiter returns whatever the ALU produces (0, eq 0). The arbiter does not compute or alter results.
- `last_grant` reset value 1, so requester 0 wins the first tie.
- Requester inputs are sampled only on the accept edge; changes afterwards do not affect the in-flight operation.

## Timing

- Reset (async assert, sync-safe deassert via flop): state IDLE; `alu_op1`/`alu_op2`/`alu_ctrl`=0; `resp_valid`=0; `resp_id`=0; `resp_result`=0; `resp_eq`=0; `busy`=0; `last_grant`=1. `reqX_ready` follows IDLE grant logic immediately after reset.
- Accept in cycle N (valid & ready) -> `alu_*` updated at edge N+1 -> result captured at edge N+2 -> `resp_valid` high in cycle N+2.
- If `resp_ready` high in first RESP cycle (N+2), state is IDLE in N+3 and a new accept can occur in N+3; peak throughput one operation per 3 cycles.
- `resp_ready` high while `resp_valid`=0 is ignored.
- `rst_n` asserted mid-operation (EXEC or RESP): in-flight operation discarded, no response, all outputs to reset values asynchronously.
- Requester deasserting `valid` without `ready` is legal; no state change.

## Test plan

- Reset: assert `rst_n`=0 mid-RESP -> `resp_valid`=0, `busy`=0, `alu_*`=0 immediately; after release, tie goes to requester 0.
- Single requester: req0 add 5+7 accepted cycle N -> `resp_valid` cycle N+2 with `resp_id`=0, `resp_result`=12, `resp_eq`=0.
- Sub eq: req1 sub 0x20-0x20 -> `resp_result`=0, `resp_eq`=1, `resp_id`=1; sub 3-5 -> result 0xFFFFFFFE, eq 0.
- Contention: both valid continuously with `resp_ready`=1 -> grants alternate 0,1,0,1; accepts every 3 cycles; non-granted `ready` always 0.
- Backpressure: hold `resp_ready`=0 for 10 cycles -> response fields stable, both `ready`=0, `busy`=1; release -> IDLE next cycle.
- Operand isolation: change req0 operands the cycle after accept -> response reflects originally accepted values; reserved ctrl 5 -> result 0, eq 0.
